// File: rtl/reg_wb_pkg.sv
// Shared types for the register-file write-port arbiter: widths, the queued
// result entry and the grant source encoding.
package reg_wb_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    PIPE = 2'd1,
    LU   = 2'd2
  } grant_src_e;

endpackage

// File: rtl/reg_wb_fifo.sv
// Small circular FIFO of long-latency results; exposes every slot's address and
// valid bit so the hazard lookup can see everything still waiting for the port.
module reg_wb_fifo
  import reg_wb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  push_i,
  input  wb_entry_t                             push_entry_i,
  input  logic                                  pop_i,
  output wb_entry_t                             head_o,
  output logic [CNT_W-1:0]                      count_o,
  output logic [DEPTH-1:0]                      vld_o,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]      addr_o
);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && (count_q != CNT_W'(DEPTH));

  always_comb begin
    vld_d   = vld_q;
    count_d = count_q;
    if (do_pop) vld_d[rd_ptr_q] = 1'b0;
    if (do_push) vld_d[wr_ptr_q] = 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      vld_q   <= vld_d;
    end
  end

  // Payload storage carries no reset; slot validity lives in vld_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) addr_o[i] = mem_q[i].addr;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign vld_o   = vld_q;

endmodule

// File: rtl/reg_wb_arbiter.sv
// Arbitrates the register file write port between the pipeline writeback and
// queued long-latency results. Optional macro REG_WB_ARB_BYPASS_EN lets an idle port take a result directly.
module reg_wb_arbiter
  import reg_wb_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  lu_valid,
  input  logic [REG_ADDR_W-1:0] lu_addr,
  input  logic [XLEN-1:0]       lu_data,
  output logic                  lu_ready,
  output logic                  wb_stall,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  rs1_pending,
  output logic                  rs2_pending,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] Wt_addr,
  output logic [XLEN-1:0]       Wt_data
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  wb_entry_t                        fifo_head, win_entry;
  logic [CNT_W-1:0]                 fifo_count;
  logic [DEPTH-1:0]                 fifo_vld;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] fifo_addr;
  logic                             fifo_empty, fifo_push, fifo_pop;
  logic                             lu_acc, lu_bypass;
  grant_src_e                       gnt_src;
  logic [STV_W-1:0]                 starve_q, starve_d;
  logic                             RegWrite_q;
  logic [REG_ADDR_W-1:0]            Wt_addr_q;
  logic [XLEN-1:0]                  Wt_data_q;

  function automatic logic addr_pending(
    input logic [REG_ADDR_W-1:0]            a,
    input logic [DEPTH-1:0]                 vld,
    input logic [DEPTH-1:0][REG_ADDR_W-1:0] addrs,
    input logic                             rw,
    input logic [REG_ADDR_W-1:0]            wa
  );
    logic hit;
    hit = rw && (wa == a);
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && (addrs[i] == a)) hit = 1'b1;
    end
    return hit && (a != '0);
  endfunction

  reg_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (fifo_push),
    .push_entry_i ('{addr: lu_addr, data: lu_data}),
    .pop_i        (fifo_pop),
    .head_o       (fifo_head),
    .count_o      (fifo_count),
    .vld_o        (fifo_vld),
    .addr_o       (fifo_addr)
  );

  assign fifo_empty = (fifo_count == '0);
  assign lu_ready   = (fifo_count < CNT_W'(DEPTH));
  assign lu_acc     = lu_valid && lu_ready;
  assign wb_stall   = (starve_q == STV_W'(STARVE_MAX));

  // A stalled pipeline yields the port to the starving head; otherwise the pipeline wins.
  always_comb begin
    gnt_src   = NONE;
    fifo_pop  = 1'b0;
    lu_bypass = 1'b0;
    if (wb_stall) begin
      gnt_src  = LU;
      fifo_pop = 1'b1;
    end else if (wb_valid && (wb_addr != '0)) begin
      gnt_src = PIPE;
    end else if (!fifo_empty) begin
      gnt_src  = LU;
      fifo_pop = 1'b1;
    end
`ifdef REG_WB_ARB_BYPASS_EN
    else if (lu_acc && (lu_addr != '0)) begin
      gnt_src   = LU;
      lu_bypass = 1'b1;
    end
`endif
  end

  always_comb begin
    win_entry = fifo_head;
    if (gnt_src == PIPE) win_entry = '{addr: wb_addr, data: wb_data};
    else if (lu_bypass)  win_entry = '{addr: lu_addr, data: lu_data};
  end

  // Address-0 results are accepted by the handshake but never stored.
  assign fifo_push = lu_acc && (lu_addr != '0) && !lu_bypass;
  assign starve_d  = (fifo_pop || fifo_empty) ? '0 : starve_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q   <= '0;
      RegWrite_q <= 1'b0;
      Wt_addr_q  <= '0;
      Wt_data_q  <= '0;
    end else begin
      starve_q   <= starve_d;
      RegWrite_q <= (gnt_src != NONE);
      if (gnt_src != NONE) begin
        Wt_addr_q <= win_entry.addr;
        Wt_data_q <= win_entry.data;
      end
    end
  end

  assign RegWrite    = RegWrite_q;
  assign Wt_addr     = Wt_addr_q;
  assign Wt_data     = Wt_data_q;
  assign rs1_pending = addr_pending(rs1_addr, fifo_vld, fifo_addr, RegWrite_q, Wt_addr_q);
  assign rs2_pending = addr_pending(rs2_addr, fifo_vld, fifo_addr, RegWrite_q, Wt_addr_q);

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Randomised and directed bench for reg_wb_arbiter against a queue-based reference
// model; follows REG_WB_ARB_BYPASS_EN when it is defined.
module tb_reg_wb_arbiter;

  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid, lu_valid;
  logic [4:0]  wb_addr, lu_addr, rs1_addr, rs2_addr;
  logic [31:0] wb_data, lu_data;
  logic        lu_ready, wb_stall, rs1_pending, rs2_pending;
  logic        RegWrite;
  logic [4:0]  Wt_addr;
  logic [31:0] Wt_data;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: queue of {addr,data}, starvation age, write port.
  logic [36:0] mq[$];
  int          m_starve;
  logic        m_rw;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;

  logic [41:0] obs, expv;

  reg_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .lu_valid(lu_valid), .lu_addr(lu_addr), .lu_data(lu_data),
    .lu_ready(lu_ready), .wb_stall(wb_stall),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_pending(rs1_pending), .rs2_pending(rs2_pending),
    .RegWrite(RegWrite), .Wt_addr(Wt_addr), .Wt_data(Wt_data)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    mq.delete();
    m_starve = 0;
    m_rw = 1'b0;
    m_wa = '0;
    m_wd = '0;
  endtask

  function automatic logic model_pending(input logic [4:0] a);
    logic hit;
    hit = m_rw && (m_wa == a);
    foreach (mq[i]) if (mq[i][36:32] == a) hit = 1'b1;
    return hit && (a != 5'd0);
  endfunction

  function automatic logic [41:0] model_exp();
    return {m_rw, m_wa, m_wd, (mq.size() < DEPTH), (m_starve == STARVE_MAX),
            model_pending(rs1_addr), model_pending(rs2_addr)};
  endfunction

  // One clock of the arbiter, straight from the priority and queueing rules.
  task automatic model_step();
    bit stall, acc, popped, wrote, byp;
    int pre;
    logic [36:0] w;
    stall  = (m_starve == STARVE_MAX);
    pre    = mq.size();
    acc    = lu_valid && (pre < DEPTH);
    popped = 0; wrote = 0; byp = 0; w = '0;
    if (stall) begin
      w = mq.pop_front(); popped = 1; wrote = 1;
    end else if (wb_valid && wb_addr != 5'd0) begin
      w = {wb_addr, wb_data}; wrote = 1;
    end else if (pre > 0) begin
      w = mq.pop_front(); popped = 1; wrote = 1;
    end
`ifdef REG_WB_ARB_BYPASS_EN
    else if (acc && lu_addr != 5'd0) begin
      w = {lu_addr, lu_data}; wrote = 1; byp = 1;
    end
`endif
    if (acc && lu_addr != 5'd0 && !byp) mq.push_back({lu_addr, lu_data});
    m_starve = (popped || pre == 0) ? 0 : m_starve + 1;
    m_rw = wrote;
    if (wrote) {m_wa, m_wd} = w;
  endtask

  task automatic drive(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld,
                       input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clk);
    wb_valid = wv; wb_addr = wa; wb_data = wd;
    lu_valid = lv; lu_addr = la; lu_data = ld;
    rs1_addr = r1; rs2_addr = r2;
    #1;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    lu_valid = 1'b0; lu_addr = '0; lu_data = '0;
    rs1_addr = 5'd5; rs2_addr = 5'd7;
    repeat (2) @(negedge clk);
    #1;
    obs = {RegWrite, Wt_addr, Wt_data, lu_ready, wb_stall, rs1_pending, rs2_pending};
    n_vec++;
    if (obs !== {1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL reset_state got %h want %h", obs, {1'b0, 5'd0, 32'd0, 4'b1000});
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_pipe_write();
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    obs = {RegWrite, Wt_addr, Wt_data, lu_ready, wb_stall, rs1_pending, rs2_pending};
    expv = model_exp(); n_vec++;
    if (obs !== expv) begin n_err++; $display("FAIL pipe_req got %h want %h", obs, expv); end
    tick();
    drive(1'b1, 5'd0, 32'h1234_5678, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    n_vec++;
    if ({RegWrite, Wt_addr, Wt_data, rs1_pending} !== {1'b1, 5'd5, 32'hDEADBEEF, 1'b1}) begin
      n_err++; $display("FAIL pipe_write got %b %0d %h %b want 1 5 deadbeef 1", RegWrite, Wt_addr, Wt_data, rs1_pending);
    end
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    n_vec++;
    if ({RegWrite, Wt_addr, Wt_data} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
      n_err++; $display("FAIL pipe_addr0 got %b %0d %h want 0 5 deadbeef", RegWrite, Wt_addr, Wt_data);
    end
    tick();
  endtask

  task automatic test_starve();
    int stall_k = -1;
    drive(1'b1, 5'd3, $urandom, 1'b1, 5'd7, 32'h11, 5'd7, 5'd3);
    tick();
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 5'd3, $urandom, 1'b0, 5'd0, 32'd0, 5'd7, 5'd3);
      obs = {RegWrite, Wt_addr, Wt_data, lu_ready, wb_stall, rs1_pending, rs2_pending};
      expv = model_exp(); n_vec++;
      if (obs !== expv) begin n_err++; $display("FAIL starve_cyc%0d got %h want %h", k, obs, expv); end
      if (wb_stall && stall_k < 0) stall_k = k;
      if (k == 6) begin
        n_vec++;
        if ({RegWrite, Wt_addr, Wt_data, rs1_pending} !== {1'b1, 5'd7, 32'h11, 1'b1}) begin
          n_err++; $display("FAIL starve_write got %b %0d %h %b want 1 7 11 1", RegWrite, Wt_addr, Wt_data, rs1_pending);
        end
      end
      if (k == 7) begin
        n_vec++;
        if (rs1_pending !== 1'b0) begin n_err++; $display("FAIL starve_clear got %b want 0", rs1_pending); end
      end
      tick();
    end
    n_vec++;
    if (stall_k != 5) begin n_err++; $display("FAIL starve_cycle got %0d want 5", stall_k); end
  endtask

  task automatic test_full();
    logic [4:0]  la[3];
    logic [31:0] ld[3];
    logic [4:0]  sa[3];
    logic [31:0] sd[3];
    logic [4:0]  cur_a;
    logic [31:0] cur_d;
    int idx = 0, got = 0;
    bit saw_full = 0, acc;
    la[0] = 5'd10; la[1] = 5'd11; la[2] = 5'd12;
    for (int i = 0; i < 3; i++) ld[i] = $urandom;
    for (int c = 0; c < 60 && got < 3; c++) begin
      cur_a = (idx < 3) ? la[idx] : 5'd0;
      cur_d = (idx < 3) ? ld[idx] : 32'd0;
      drive(1'b1, 5'd3, $urandom, idx < 3, cur_a, cur_d, 5'd10, 5'd12);
      obs = {RegWrite, Wt_addr, Wt_data, lu_ready, wb_stall, rs1_pending, rs2_pending};
      expv = model_exp(); n_vec++;
      if (obs !== expv) begin n_err++; $display("FAIL full_cyc%0d got %h want %h", c, obs, expv); end
      if (RegWrite && Wt_addr >= 5'd10 && Wt_addr <= 5'd12) begin
        sa[got] = Wt_addr; sd[got] = Wt_data; got++;
      end
      if (idx == 2 && !lu_ready) saw_full = 1;
      acc = (idx < 3) && lu_ready;
      tick();
      if (acc) idx++;
    end
    n_vec++;
    if (!saw_full) begin n_err++; $display("FAIL full_ready got 1 want 0 after two accepts"); end
    n_vec++;
    if (got != 3) begin
      n_err++; $display("FAIL full_drain got %0d writes want 3", got);
    end else begin
      for (int i = 0; i < 3; i++) begin
        if ({sa[i], sd[i]} !== {la[i], ld[i]}) begin
          n_err++; $display("FAIL full_order%0d got %0d %h want %0d %h", i, sa[i], sd[i], la[i], ld[i]);
        end
      end
    end
    idle(2);
  endtask

  task automatic test_wrap();
    logic [4:0]  pa[10];
    logic [31:0] pd[10];
    logic [4:0]  cur_a;
    logic [31:0] cur_d;
    int got = 0;
    idle(2);
    for (int i = 0; i < 10; i++) begin pa[i] = 5'($urandom_range(1, 31)); pd[i] = $urandom; end
    for (int c = 0; c < 16; c++) begin
      cur_a = (c < 10) ? pa[c] : 5'd0;
      cur_d = (c < 10) ? pd[c] : 32'd0;
      drive(1'b0, 5'd0, 32'd0, c < 10, cur_a, cur_d, pa[0], pa[9]);
      obs = {RegWrite, Wt_addr, Wt_data, lu_ready, wb_stall, rs1_pending, rs2_pending};
      expv = model_exp(); n_vec++;
      if (obs !== expv) begin n_err++; $display("FAIL wrap_cyc%0d got %h want %h", c, obs, expv); end
      if (RegWrite && got < 10) begin
        n_vec++;
        if ({Wt_addr, Wt_data} !== {pa[got], pd[got]}) begin
          n_err++; $display("FAIL wrap_order%0d got %0d %h want %0d %h", got, Wt_addr, Wt_data, pa[got], pd[got]);
        end
        got++;
      end
      tick();
    end
    n_vec++;
    if (got != 10) begin n_err++; $display("FAIL wrap_count got %0d want 10", got); end
  endtask

  task automatic test_lu_latency();
    int k = -1;
    int want;
`ifdef REG_WB_ARB_BYPASS_EN
    want = 1;
`else
    want = 2;
`endif
    idle(2);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hCAFE_0009, 5'd9, 5'd0);
    tick();
    for (int c = 1; c <= 5; c++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
      obs = {RegWrite, Wt_addr, Wt_data, lu_ready, wb_stall, rs1_pending, rs2_pending};
      expv = model_exp(); n_vec++;
      if (obs !== expv) begin n_err++; $display("FAIL lat_cyc%0d got %h want %h", c, obs, expv); end
      if (RegWrite && k < 0) begin
        k = c;
        n_vec++;
        if ({Wt_addr, Wt_data} !== {5'd9, 32'hCAFE_0009}) begin
          n_err++; $display("FAIL lat_data got %0d %h want 9 cafe0009", Wt_addr, Wt_data);
        end
      end
      tick();
    end
    n_vec++;
    if (k != want) begin n_err++; $display("FAIL lat_cycles got %0d want %0d", k, want); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 5'd3, $urandom, 1'b1, 5'd20, $urandom, 5'd20, 5'd21);
    tick();
    drive(1'b1, 5'd3, $urandom, 1'b1, 5'd21, $urandom, 5'd20, 5'd21);
    tick();
    drive(1'b1, 5'd3, $urandom, 1'b0, 5'd0, 32'd0, 5'd20, 5'd21);
    obs = {RegWrite, Wt_addr, Wt_data, lu_ready, wb_stall, rs1_pending, rs2_pending};
    expv = model_exp(); n_vec++;
    if (obs !== expv) begin n_err++; $display("FAIL rstmid_pre got %h want %h", obs, expv); end
    rst = 1'b1;
    wb_valid = 1'b0; lu_valid = 1'b0;
    #1;
    obs = {RegWrite, Wt_addr, Wt_data, lu_ready, wb_stall, rs1_pending, rs2_pending};
    n_vec++;
    if (obs !== {1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL rstmid_async got %h want %h", obs, {1'b0, 5'd0, 32'd0, 4'b1000});
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd20, 5'd21);
      n_vec++;
      if ({RegWrite, rs1_pending, rs2_pending, lu_ready} !== 4'b0001) begin
        n_err++; $display("FAIL rstmid_stale%0d got %b%b%b%b want 0001", c, RegWrite, rs1_pending, rs2_pending, lu_ready);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 9) < 4, 5'($urandom_range(0, 15)), $urandom,
            5'($urandom_range(0, 15)), 5'($urandom_range(0, 31)));
      obs = {RegWrite, Wt_addr, Wt_data, lu_ready, wb_stall, rs1_pending, rs2_pending};
      expv = model_exp(); n_vec++;
      if (obs !== expv) begin n_err++; $display("FAIL rand_cyc%0d got %h want %h", c, obs, expv); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_pipe_write();
    test_starve();
    test_full();
    test_wrap();
    test_lu_latency();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
